// File: rtl/adc_period_meter.sv
// Capture side of the parallel 8-bit converter: drives ad_clk, samples ad_db and
// measures the input period with a hysteresis zero-crossing detector, averaged over 2^AVG_LOG2 periods.
module adc_period_meter #(
  parameter int unsigned MID      = 128,
  parameter int unsigned HYST     = 8,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ad_clk,
  input  logic [7:0]  ad_db,
  output logic [7:0]  sample,
  output logic [31:0] period,
  output logic [31:0] period_sum,
  output logic        period_valid,
  output logic        no_signal
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned EDGE_W = AVG_LOG2 + 1;
  localparam int unsigned HI_RAW = MID + HYST;
  localparam int unsigned LO_TH  = (MID >= HYST) ? (MID - HYST) : 0;
  localparam int unsigned HI_TH  = (HI_RAW > 255) ? 255 : HI_RAW;

  localparam logic [DATA_W-1:0] LO_CODE     = DATA_W'(LO_TH);
  localparam logic [DATA_W-1:0] HI_CODE     = DATA_W'(HI_TH);
  localparam logic [EDGE_W-1:0] EDGE_TARGET = EDGE_W'(1 << AVG_LOG2);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {CMP_UNARMED, CMP_LOW, CMP_HIGH} cmp_e;
  typedef enum logic       {ST_SEARCH, ST_MEASURE}          state_e;

  state_e              state, state_nxt;
  cmp_e                cmp, cmp_step, cmp_nxt;
  logic                eval;
  logic                rise_c;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0]    acc, acc_nxt, acc_sat;
  logic [CNT_W:0]      acc_add;
  logic [EDGE_W-1:0]   edges, edges_nxt, edges_inc;
  logic [CNT_W-1:0]    period_nxt, sum_nxt;
  logic                valid_nxt, nosig_nxt;

  // Sample strobe: ad_clk high marks the capture cycle; eval flags the cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ad_clk <= 1'b0;
      sample <= '0;
      eval   <= 1'b0;
    end else begin
      ad_clk <= ~ad_clk;
      eval   <= ad_clk;
      if (ad_clk) sample <= ad_db;
    end
  end

  // Hysteresis comparator; a rise needs a previously observed low phase.
  always_comb begin
    cmp_step = cmp;
    rise_c   = 1'b0;
    if (eval) begin
      case (cmp)
        CMP_UNARMED: if (sample <= LO_CODE) cmp_step = CMP_LOW;
        CMP_LOW: begin
          if (sample >= HI_CODE) begin
            cmp_step = CMP_HIGH;
            rise_c   = 1'b1;
          end
        end
        CMP_HIGH:    if (sample <= LO_CODE) cmp_step = CMP_LOW;
        default:     cmp_step = CMP_UNARMED;
      endcase
    end
  end

  // Period accumulation FSM; a rise on the same cycle as a timeout takes priority.
  always_comb begin
    state_nxt  = state;
    cmp_nxt    = cmp_step;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    edges_nxt  = edges;
    period_nxt = period;
    sum_nxt    = period_sum;
    valid_nxt  = 1'b0;
    nosig_nxt  = no_signal;
    acc_add    = {1'b0, acc} + {1'b0, cnt};
    acc_sat    = acc_add[CNT_W] ? CNT_MAX : acc_add[CNT_W-1:0];
    edges_inc  = edges + EDGE_W'(1);

    if (ad_clk && (cnt != CNT_MAX)) cnt_nxt = cnt + CNT_W'(1);

    if (rise_c) begin
      cnt_nxt = CNT_W'(ad_clk);
      case (state)
        ST_SEARCH: begin
          state_nxt = ST_MEASURE;
          acc_nxt   = '0;
          edges_nxt = '0;
        end
        ST_MEASURE: begin
          if (edges_inc == EDGE_TARGET) begin
            sum_nxt    = acc_sat;
            period_nxt = acc_sat >> AVG_LOG2;
            valid_nxt  = 1'b1;
            nosig_nxt  = 1'b0;
            acc_nxt    = '0;
            edges_nxt  = '0;
          end else begin
            acc_nxt   = acc_sat;
            edges_nxt = edges_inc;
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end else if (cnt >= TIMEOUT_CNT) begin
      // Counter restarts so the comparator can re-arm while no_signal stays latched.
      nosig_nxt = 1'b1;
      state_nxt = ST_SEARCH;
      cmp_nxt   = CMP_UNARMED;
      acc_nxt   = '0;
      edges_nxt = '0;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SEARCH;
      cmp          <= CMP_UNARMED;
      cnt          <= '0;
      acc          <= '0;
      edges        <= '0;
      period       <= '0;
      period_sum   <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cmp          <= cmp_nxt;
      cnt          <= cnt_nxt;
      acc          <= acc_nxt;
      edges        <= edges_nxt;
      period       <= period_nxt;
      period_sum   <= sum_nxt;
      period_valid <= valid_nxt;
      no_signal    <= nosig_nxt;
    end
  end

endmodule

// File: tb/tb_adc_period_meter.sv
// Directed bench for adc_period_meter: a sample-domain reference model queues expected
// results as samples are driven; a monitor pops and compares them on every period_valid.
module tb_adc_period_meter;

  localparam int unsigned TIMEOUT  = 1000;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned AVG_N    = 1 << AVG_LOG2;
  localparam int unsigned LO_TH    = 120;
  localparam int unsigned HI_TH    = 136;
  localparam int          M_UN = 0, M_LO = 1, M_HI = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ad_clk;
  logic [7:0]  ad_db = 8'd200;
  logic [7:0]  sample;
  logic [31:0] period;
  logic [31:0] period_sum;
  logic        period_valid;
  logic        no_signal;

  always #5 clk = ~clk;

  adc_period_meter #(
    .MID(128), .HYST(8), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ad_clk(ad_clk), .ad_db(ad_db), .sample(sample),
    .period(period), .period_sum(period_sum), .period_valid(period_valid),
    .no_signal(no_signal)
  );

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] sum;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state, advanced once per driven sample.
  int          m_cmp   = M_UN;
  bit          m_meas  = 1'b0;
  bit          m_nosig = 1'b0;
  longint      m_cnt   = 0;
  longint      m_acc   = 0;
  int unsigned m_edges = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cmp = M_UN; m_meas = 1'b0; m_nosig = 1'b0;
    m_cnt = 0; m_acc = 0; m_edges = 0;
  endtask

  task automatic model_step(input logic [7:0] s);
    bit   rise = 1'b0;
    exp_t e;
    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    case (m_cmp)
      M_UN: if (s <= LO_TH) m_cmp = M_LO;
      M_LO: if (s >= HI_TH) begin m_cmp = M_HI; rise = 1'b1; end
      default: if (s <= LO_TH) m_cmp = M_LO;
    endcase
    if (rise) begin
      if (m_meas) begin
        m_acc = m_acc + m_cnt;
        if (m_acc > 64'hFFFF_FFFF) m_acc = 64'hFFFF_FFFF;
        m_edges++;
        if (m_edges == AVG_N) begin
          e.sum    = 32'(m_acc);
          e.period = 32'(m_acc >> AVG_LOG2);
          exp_q.push_back(e);
          m_nosig = 1'b0;
          m_acc   = 0;
          m_edges = 0;
        end
      end else begin
        m_meas = 1'b1; m_acc = 0; m_edges = 0;
      end
      m_cnt = 0;
    end else if (m_cnt >= TIMEOUT) begin
      m_nosig = 1'b1; m_meas = 1'b0; m_cmp = M_UN; m_acc = 0; m_edges = 0; m_cnt = 0;
    end
  endtask

  // Drive one sample just before the capturing strobe edge.
  task automatic feed(input logic [7:0] v);
    int guard = 0;
    @(negedge clk);
    while (ad_clk !== 1'b1) begin
      guard++;
      if (guard > 4) begin
        $display("FAIL strobe_wait: ad_clk stuck at %b expected toggling", ad_clk);
        $fatal(1, "strobe never arrived");
      end
      @(negedge clk);
    end
    check("no_signal_track", 32'(no_signal), 32'(m_nosig));
    ad_db = v;
    model_step(v);
  endtask

  task automatic square(input int half, input int n_periods);
    for (int p = 0; p < n_periods; p++) begin
      for (int i = 0; i < half; i++) feed(8'd0);
      for (int i = 0; i < half; i++) feed(8'd255);
    end
  endtask

  task automatic dither(input int n_periods);
    for (int p = 0; p < n_periods; p++) begin
      for (int i = 0; i < 45; i++) feed(8'd60);
      for (int i = 0; i < 5; i++)  feed((i % 2 == 0) ? 8'd125 : 8'd131);
      for (int i = 0; i < 45; i++) feed(8'd196);
      for (int i = 0; i < 5; i++)  feed((i % 2 == 0) ? 8'd131 : 8'd125);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest queued result and last one cycle.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_valid) check("valid_one_cycle", 32'(period_valid), 32'd0);
      else if (period_valid === 1'b1) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'(period_valid), 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("period", period, e.period);
          check("period_sum", period_sum, e.sum);
          check("no_signal_on_valid", 32'(no_signal), 32'd0);
        end
      end
      prev_valid = (period_valid === 1'b1);
    end else prev_valid = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with an above-threshold input: nothing may arm.
    rst   = 1'b1;
    ad_db = 8'd200;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_ad_clk", 32'(ad_clk), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_period", period, 32'd0);
    check("rst_period_sum", period_sum, 32'd0);
    check("rst_valid", 32'(period_valid), 32'd0);
    check("rst_no_signal", 32'(no_signal), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ad_clk_rise", 32'(ad_clk), 32'd1);
    @(negedge clk);
    check("ad_clk_fall", 32'(ad_clk), 32'd0);
    repeat (30) feed(8'd200);
    check("sample_capture", 32'(sample), 32'd200);

    // Square wave, period 100 strobes.
    square(50, 9);
    check("square_period", period, 32'd100);
    check("square_sum", period_sum, 32'd400);

    // In-band dither around the crossings must not add rises.
    dither(8);
    check("dither_period", period, 32'd100);

    // Small sine then flat mid-code: timeout, period holds.
    for (int i = 0; i < 600; i++)
      feed(8'(int'(128.0 + 5.0 * $sin(2.0 * 3.14159265 * real'(i) / 50.0))));
    for (int i = 0; i < 600; i++) feed(8'd128);
    check("timeout_no_signal", 32'(no_signal), 32'd1);
    check("timeout_period_hold", period, 32'd100);
    check("timeout_sum_hold", period_sum, 32'd400);

    // Recovery.
    square(50, 6);
    check("recover_no_signal", 32'(no_signal), 32'd0);
    check("recover_period", period, 32'd100);

    // Frequency step to period 64 mid-window.
    square(32, 11);
    check("step_period", period, 32'd64);
    check("step_sum", period_sum, 32'd256);

    // Reset mid-window discards the partial sum.
    square(32, 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_period", period, 32'd0);
    check("mid_rst_sum", period_sum, 32'd0);
    check("mid_rst_valid", 32'(period_valid), 32'd0);
    check("mid_rst_sample", 32'(sample), 32'd0);
    rst = 1'b0;
    model_reset();
    square(50, 5);
    repeat (10) feed(8'd255);
    check("post_rst_period", period, 32'd100);
    check("post_rst_sum", period_sum, 32'd400);
    check("pending_results", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
